// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU data, instruction fetch) arbiter for the SoC memory/MMIO bus.
// Optional ACCESS timeout is compiled in with `define MEM_BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic [3:0]          s_sel,
  output logic                s_valid,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata
);

  localparam int STRB_W = DATA_W / 8;

  // Slave windows in select-bit order {VGA, TIMER, ROM, RAM}: base and size-1.
  localparam logic [ADDR_W-1:0] SLV_BASE [0:3] = '{
    ADDR_W'(64'h0000_0000), ADDR_W'(64'h1000_0000),
    ADDR_W'(64'h2000_0000), ADDR_W'(64'h2000_0008)
  };
  localparam logic [ADDR_W-1:0] SLV_MASK [0:3] = '{
    ADDR_W'(64'h00FF_FFFF), ADDR_W'(64'h000F_FFFF),
    ADDR_W'(64'h0000_0007), ADDR_W'(64'h0000_0007)
  };

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t              state_reg;
  logic                last_grant_reg;   // 1 = m1 was granted last
  logic                owner_reg;        // master owning the current transaction
  logic [3:0]          s_sel_reg;
  logic                s_valid_reg;
  logic                s_we_reg;
  logic [ADDR_W-1:0]   s_addr_reg;
  logic [DATA_W-1:0]   s_wdata_reg;
  logic [STRB_W-1:0]   s_wstrb_reg;
  logic                m0_rvalid_reg;
  logic [DATA_W-1:0]   m0_rdata_reg;
  logic                m0_err_reg;
  logic                m1_rvalid_reg;
  logic [DATA_W-1:0]   m1_rdata_reg;
  logic                m1_err_reg;

  logic                pick_valid;
  logic                pick_m1;
  logic [ADDR_W-1:0]   pick_addr;
  logic                pick_we;
  logic [DATA_W-1:0]   pick_wdata;
  logic [STRB_W-1:0]   pick_wstrb;
  logic [3:0]          pick_hit;
  logic                pick_legal;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] to_cnt_reg;
`endif

  // Round-robin choice; gated by rst_n so no grant is shown while in reset.
  always_comb begin
    pick_valid = 1'b0;
    pick_m1    = 1'b0;
    if (rst_n && state_reg == ST_IDLE) begin
      if (m0_req && m1_req) begin
        pick_valid = 1'b1;
        pick_m1    = ~last_grant_reg;
      end else if (m0_req) begin
        pick_valid = 1'b1;
      end else if (m1_req) begin
        pick_valid = 1'b1;
        pick_m1    = 1'b1;
      end
    end
  end

  always_comb begin
    pick_addr  = pick_m1 ? m1_addr : m0_addr;
    pick_we    = pick_m1 ? 1'b0 : m0_we;
    pick_wdata = pick_m1 ? '0 : m0_wdata;
    pick_wstrb = pick_m1 ? '0 : m0_wstrb;
  end

  // Offset compare: addresses below a base wrap to a large offset and miss.
  for (genvar gi = 0; gi < 4; gi++) begin : g_decode
    logic [ADDR_W-1:0] offset;
    assign offset       = pick_addr - SLV_BASE[gi];
    assign pick_hit[gi] = (offset <= SLV_MASK[gi]);
  end

  assign pick_legal = (pick_hit != 4'b0000) && !(pick_we && pick_hit[1]);

  assign m0_gnt = pick_valid & ~pick_m1;
  assign m1_gnt = pick_valid & pick_m1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      s_sel_reg      <= '0;
      s_valid_reg    <= 1'b0;
      s_we_reg       <= 1'b0;
      s_addr_reg     <= '0;
      s_wdata_reg    <= '0;
      s_wstrb_reg    <= '0;
      m0_rvalid_reg  <= 1'b0;
      m0_rdata_reg   <= '0;
      m0_err_reg     <= 1'b0;
      m1_rvalid_reg  <= 1'b0;
      m1_rdata_reg   <= '0;
      m1_err_reg     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      to_cnt_reg     <= '0;
`endif
    end else begin
      m0_rvalid_reg <= 1'b0;
      m0_rdata_reg  <= '0;
      m0_err_reg    <= 1'b0;
      m1_rvalid_reg <= 1'b0;
      m1_rdata_reg  <= '0;
      m1_err_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            last_grant_reg <= pick_m1;
            owner_reg      <= pick_m1;
            s_we_reg       <= pick_we;
            s_addr_reg     <= pick_addr;
            s_wdata_reg    <= pick_wdata;
            s_wstrb_reg    <= pick_wstrb;
            if (pick_legal) begin
              state_reg   <= ST_ACCESS;
              s_valid_reg <= 1'b1;
              s_sel_reg   <= pick_hit;
`ifdef MEM_BUS_TIMEOUT_EN
              to_cnt_reg  <= '0;
`endif
            end else begin
              // Decode error: answer straight away without touching any slave.
              state_reg <= ST_RESP;
              if (pick_m1) begin
                m1_rvalid_reg <= 1'b1;
                m1_err_reg    <= 1'b1;
              end else begin
                m0_rvalid_reg <= 1'b1;
                m0_err_reg    <= 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (s_ready) begin
            state_reg   <= ST_RESP;
            s_valid_reg <= 1'b0;
            s_sel_reg   <= '0;
            if (owner_reg) begin
              m1_rvalid_reg <= 1'b1;
              m1_rdata_reg  <= s_rdata;
            end else begin
              m0_rvalid_reg <= 1'b1;
              m0_rdata_reg  <= s_rdata;
            end
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg   <= ST_RESP;
            s_valid_reg <= 1'b0;
            s_sel_reg   <= '0;
            if (owner_reg) begin
              m1_rvalid_reg <= 1'b1;
              m1_err_reg    <= 1'b1;
            end else begin
              m0_rvalid_reg <= 1'b1;
              m0_err_reg    <= 1'b1;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_sel     = s_sel_reg;
  assign s_valid   = s_valid_reg;
  assign s_we      = s_we_reg;
  assign s_addr    = s_addr_reg;
  assign s_wdata   = s_wdata_reg;
  assign s_wstrb   = s_wstrb_reg;
  assign m0_rvalid = m0_rvalid_reg;
  assign m0_rdata  = m0_rdata_reg;
  assign m0_err    = m0_err_reg;
  assign m1_rvalid = m1_rvalid_reg;
  assign m1_rdata  = m1_rdata_reg;
  assign m1_err    = m1_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a scoreboard of expected responses.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [63:0] m0_addr = '0, m0_wdata = '0;
  logic [7:0]  m0_wstrb = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [63:0] m0_rdata;
  logic        m1_req = 1'b0;
  logic [63:0] m1_addr = '0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [63:0] m1_rdata;
  logic [3:0]  s_sel;
  logic        s_valid, s_we;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [63:0] s_rdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_sel(s_sel), .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  typedef struct {
    int          m;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [3:0]  sel;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          vcyc;
    int          delay;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, gnt_cyc = 0, vcount = 0, acc_cnt = 0, last_rv_cyc = -10;
  bit   chk_b2b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request and push the response the bench expects for it.
  // sel==0 marks an access the arbiter must reject (unmapped or ROM write).
  task automatic issue(input int m, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wstrb,
                       input logic [3:0] sel, input logic [63:0] rd, input int delay);
    exp_t e;
    e.m     = m;
    e.we    = (m == 0) ? we : 1'b0;
    e.addr  = addr;
    e.wdata = (m == 0) ? wdata : 64'h0;
    e.wstrb = (m == 0) ? wstrb : 8'h0;
    e.sel   = sel;
    e.err   = (sel == 4'b0000);
    e.rdata = e.err ? 64'h0 : rd;
    e.delay = delay;
    e.lat   = e.err ? 1 : 2 + delay;
    e.vcyc  = e.err ? 0 : delay + 1;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_req = 1'b1; m1_addr = addr;
    end
    q.push_back(e);
  endtask

  task automatic step();
    bit g0, g1;
    exp_t e;
    logic [63:0] rd;
    logic er;
    #1;
    g0 = m0_gnt; g1 = m1_gnt;
    if (g0 || g1) begin
      chk("gnt_onehot", 64'(g0 & g1), 64'h0);
      grant_log.push_back(g1 ? 1 : 0);
      gnt_cyc = cyc;
      vcount  = 0;
      if (chk_b2b && g1) chk("b2b_gnt_cycle", 64'(cyc), 64'(last_rv_cyc + 1));
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g0) m0_req = 1'b0;
    if (g1) m1_req = 1'b0;
    if (s_valid) acc_cnt++; else acc_cnt = 0;
    s_ready = s_valid && (q.size() > 0) && (acc_cnt > q[0].delay);
    #1;
    if (s_valid) begin
      vcount++;
      if (q.size() == 0) chk("s_valid_unexpected", 64'(s_valid), 64'h0);
      else begin
        chk("s_sel", 64'(s_sel), 64'(q[0].sel));
        chk("s_we", 64'(s_we), 64'(q[0].we));
        chk("s_addr", s_addr, q[0].addr);
        chk("s_wdata", s_wdata, q[0].wdata);
        chk("s_wstrb", 64'(s_wstrb), 64'(q[0].wstrb));
      end
    end else begin
      chk("s_sel_idle", 64'(s_sel), 64'h0);
    end
    if (!m0_rvalid) chk("m0_quiet", m0_rdata | 64'(m0_err), 64'h0);
    if (!m1_rvalid) chk("m1_quiet", m1_rdata | 64'(m1_err), 64'h0);
    if (m0_rvalid || m1_rvalid) begin
      if (q.size() == 0) chk("rvalid_unexpected", 64'(m0_rvalid | m1_rvalid), 64'h0);
      else begin
        e  = q.pop_front();
        rd = m1_rvalid ? m1_rdata : m0_rdata;
        er = m1_rvalid ? m1_err : m0_err;
        chk("rvalid_master", {62'h0, m1_rvalid, m0_rvalid}, (e.m == 1) ? 64'h2 : 64'h1);
        chk("rdata", rd, e.rdata);
        chk("err", 64'(er), 64'(e.err));
        chk("latency", 64'(cyc - gnt_cyc), 64'(e.lat));
        chk("s_valid_cycles", 64'(vcount), 64'(e.vcyc));
        $display("txn master=%0d addr=%h rdata=%h err=%0d latency=%0d valid_cycles=%0d",
                 e.m, e.addr, rd, er, cyc - gnt_cyc, vcount);
      end
      last_rv_cyc = cyc;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((q.size() > 0 || m0_req || m1_req) && n < budget) begin
      step();
      n++;
    end
    chk("run_budget_left", 64'(q.size()), 64'h0);
  endtask

  logic [63:0] dec_addr [0:7];
  logic [3:0]  dec_sel  [0:7];

  initial begin
    dec_addr = '{64'h00FF_FFF8, 64'h0100_0000, 64'h100F_FFF8, 64'h1010_0000,
                 64'h2000_0000, 64'h2000_000C, 64'h2000_0010, 64'h0FFF_FFF8};
    dec_sel  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                 4'b0100, 4'b1000, 4'b0000, 4'b0000};

    // Reset state, with a request held to show gnt stays low in reset.
    m0_req = 1'b1; m0_addr = 64'h100;
    #22;
    chk("rst_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    chk("rst_s_valid", 64'(s_valid), 64'h0);
    chk("rst_s_sel", 64'(s_sel), 64'h0);
    chk("rst_rvalid", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
    chk("rst_s_addr", s_addr, 64'h0);
    m0_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // ROM fetch.
    s_rdata = 64'h0000_0000_DEAD_BEEF;
    issue(1, 1'b0, 64'h1000_0010, 64'h0, 8'h0, 4'b0010, 64'hDEAD_BEEF, 0);
    run(50);

    // Simultaneous requests twice: m0 wins both ties, m1 follows right after.
    s_rdata = 64'h1234_5678;
    for (int r = 0; r < 2; r++) begin
      grant_log.delete();
      chk_b2b = 1'b1;
      issue(0, 1'b0, 64'h100, 64'h55, 8'hFF, 4'b0001, 64'h1234_5678, 0);
      issue(1, 1'b0, 64'h1000_0000, 64'h0, 8'h0, 4'b0010, 64'h1234_5678, 0);
      run(50);
      chk_b2b = 1'b0;
      chk("tie_grants", 64'(grant_log.size()), 64'h2);
      if (grant_log.size() == 2) begin
        chk("tie_first", 64'(grant_log[0]), 64'h0);
        chk("tie_second", 64'(grant_log[1]), 64'h1);
      end
    end

    // Timer write with a slow slave.
    s_rdata = 64'h0;
    issue(0, 1'b1, 64'h2000_0004, 64'h1, 8'hF0, 4'b0100, 64'h0, 3);
    run(50);

    // Illegal accesses: ROM write, unmapped read.
    s_rdata = 64'h99;
    issue(0, 1'b1, 64'h1000_0000, 64'h77, 8'hFF, 4'b0000, 64'h0, 0);
    run(50);
    issue(0, 1'b0, 64'h3000_0000, 64'h0, 8'hFF, 4'b0000, 64'h0, 0);
    run(50);

    // Decode boundaries, alternating masters.
    for (int i = 0; i < 8; i++) begin
      s_rdata = 64'hA5A5_0000 + 64'(i);
      issue(i % 2, 1'b0, dec_addr[i], 64'h0, 8'hFF, dec_sel[i], 64'hA5A5_0000 + 64'(i), 0);
      run(50);
    end

    // VGA read with a slave that never answers in time.
    s_rdata = 64'hBEEF;
`ifdef MEM_BUS_TIMEOUT_EN
    issue(0, 1'b0, 64'h2000_0008, 64'h0, 8'h0, 4'b1000, 64'h0, 1000);
    q[q.size()-1].err   = 1'b1;
    q[q.size()-1].rdata = 64'h0;
    q[q.size()-1].lat   = 1 + TO;
    q[q.size()-1].vcyc  = TO;
`else
    issue(0, 1'b0, 64'h2000_0008, 64'h0, 8'h0, 4'b1000, 64'hBEEF, 120);
`endif
    run(300);

    // Reset in the middle of an ACCESS.
    issue(1, 1'b0, 64'h1000_0020, 64'h0, 8'h0, 4'b0010, 64'hBEEF, 50);
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_s_valid", 64'(s_valid), 64'h1);
    #1;
    rst_n = 1'b0;
    m1_req = 1'b1; m1_addr = 64'h40;
    #1;
    chk("midrst_s_valid", 64'(s_valid), 64'h0);
    chk("midrst_s_sel", 64'(s_sel), 64'h0);
    chk("midrst_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    chk("midrst_rvalid", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
    q.delete();
    acc_cnt = 0;
    s_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("inrst_s_valid", 64'(s_valid), 64'h0);
    chk("inrst_rvalid", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
    rst_n = 1'b1;
    s_rdata = 64'h4242;
    issue(1, 1'b0, 64'h40, 64'h0, 8'h0, 4'b0001, 64'h4242, 0);
    run(50);
    for (int i = 0; i < 3; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single SoC memory/MMIO bus between the CPU data port (master 0) and the instruction-fetch port (master 1). It decodes the address map (RAM, ROM, timer, VGA) into one-hot slave selects. It sequences one transaction at a time through a small FSM with a valid/ready slave handshake, and returns data or a bus error to the granted master. It sits between the core and all memory-mapped slaves.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width
- `TIMEOUT_CYCLES`, 255, maximum ACCESS cycles before a bus error (used only with timeout compiled in)

- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `m0_req` in 1: data-port request
- `m0_we` in 1: write enable
- `m0_addr` in ADDR_W: byte address
- `m0_wdata` in DATA_W: write data
- `m0_wstrb` in DATA_W/8: byte strobes
- `m0_gnt` out 1: request accepted this cycle
- `m0_rvalid` out 1: one-cycle response pulse
- `m0_rdata` out DATA_W: read data, valid with rvalid
- `m0_err` out 1: bus error, valid with rvalid
- `m1_req` in 1: instruction-fetch request, read-only
- `m1_addr` in ADDR_W: fetch address
- `m1_gnt`, `m1_rvalid`, `m1_rdata`, `m1_err` out 1/1/DATA_W/1: same meaning as the m0 outputs
- `s_sel` out 4: one-hot slave select, {VGA, TIMER, ROM, RAM}
- `s_valid` out 1: slave access valid
- `s_we` out 1: write enable to slave
- `s_addr` out ADDR_W: latched address
- `s_wdata` out DATA_W: latched write data
- `s_wstrb` out DATA_W/8: latched strobes
- `s_ready` in 1: slave completes the access
- `s_rdata` in DATA_W: slave read data, sampled when s_valid & s_ready

## Operation
- Decode (byte address):
  - RAM: 0x0000_0000–0x00FF_FFFF
  - ROM: 0x1000_0000–0x100F_FFFF
  - TIMER: 0x2000_0000–0x2000_0007 (CNT at +0, CRL at +4)
  - VGA: 0x2000_0008–0x2000_000F
  - Anything else is unmapped. A write to ROM is illegal.
- FSM has three states, IDLE, ACCESS and RESP:
  - IDLE: if any req, select a master, assert its gnt combinationally, and latch addr/we/wdata/wstrb (m1: we=0, wstrb=0).
    - Legal decode → ACCESS.
    - Unmapped or ROM write → RESP with err pending.
  - ACCESS: s_valid=1 and s_sel = decoded slave; all s_* outputs stay stable. On s_valid & s_ready, capture s_rdata → RESP.
  - RESP: pulse the granted master's rvalid for one cycle, with rdata (0 on error) and err → IDLE.
- Arbitration is round-robin on conflict. `last_grant` resets to m1, so the first tie goes to m0. A lone requester is always granted.
- Masters hold req and payload until gnt; after gnt they may drop or change them. A master must not re-request before its rvalid. The arbiter ignores req outside IDLE.
- Outputs of the non-granted master stay 0. s_sel=0 when not in ACCESS.
- Reset (any state): state=IDLE, last_grant=m1, and all outputs 0. An in-flight slave access is abandoned and no rvalid is issued.

## Timing
- Request sampled at edge E0 with gnt high in the preceding cycle.
- s_valid is high from E0 onward.
- With s_ready high in the first ACCESS cycle, rvalid is high in the cycle after E1. Minimum req→rvalid is 2 cycles after gnt.
- Error path: rvalid/err in the cycle right after the gnt cycle, with no s_valid.
- Back-to-back: the next gnt comes at the earliest in the cycle after rvalid (IDLE).
- Throughput: one transaction per 3 cycles at best.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in ACCESS.
  - If s_ready is not seen within TIMEOUT_CYCLES cycles, drop s_valid and go to RESP with err=1, rdata=0.
  - The counter clears on entry to ACCESS.
- Undefined: ACCESS waits indefinitely for s_ready. No counter logic; TIMEOUT_CYCLES is unused.

## Test plan
- **ROM fetch:** m1 reads 0x1000_0010, s_ready high immediately, s_rdata=0x0000_0000_DEAD_BEEF → s_sel=0010, one s_valid cycle, m1_rvalid with rdata 0xDEADBEEF, err=0, 2 cycles after gnt.
- **Simultaneous requests after reset:** m0 reads RAM 0x100 and m1 reads ROM 0x1000_0000 → m0 is granted first; m1 is granted in the cycle after m0_rvalid. Repeating the tie then grants m0 again (alternation).
- **Timer write:** m0 writes 0x2000_0004 with wdata=0x1, wstrb=0xF0, s_ready delayed 3 cycles → s_sel=0100, s_we=1, and the s_* outputs stay stable across all 4 ACCESS cycles; rvalid err=0.
- **Illegal accesses:** m0 writes 0x1000_0000 (ROM), then reads 0x3000_0000 (unmapped) → no s_valid for either; each returns rvalid with err=1, rdata=0.
- **Timeout (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4):** VGA read at 0x2000_0008 with s_ready held low → s_valid drops after 4 cycles; m0_rvalid err=1. Without the macro, s_valid stays high for 100+ cycles.
- **Reset mid-transaction:** rst_n low during ACCESS → s_valid, s_sel, gnt and rvalid are 0 immediately. After release, a new m1 request is granted normally.
